// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative signed/unsigned multiply/divide unit, one bit per clock
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    input  logic               cancel_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] res_o,
    output logic               dbz_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;
    logic               neg_rem;

    logic               signed_op;
    logic               s1_neg;
    logic               s2_neg;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] res_fix;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign signed_op = ~op_i[0];
    assign s1_neg    = signed_op & src1_i[WIDTH-1];
    assign s2_neg    = signed_op & src2_i[WIDTH-1];
    assign abs1      = s1_neg ? (~src1_i + 1'b1) : src1_i;
    assign abs2      = s2_neg ? (~src2_i + 1'b1) : src2_i;

    // acc = {hi, lo}: MUL shifts the product in from the top while the
    // multiplier drains out of lo; DIV shifts the dividend out of lo into hi.
    always_comb begin
        sum     = '0;
        trial   = '0;
        acc_nxt = acc;
        if (!op_q[1]) begin
            sum     = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd_q})
                             : {1'b0, acc[2*WIDTH-1:WIDTH]};
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end else begin
            trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
            if (!trial[WIDTH])
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        quo     = neg_res ? (~acc_nxt[WIDTH-1:0] + 1'b1) : acc_nxt[WIDTH-1:0];
        rem     = neg_rem ? (~acc_nxt[2*WIDTH-1:WIDTH] + 1'b1) : acc_nxt[2*WIDTH-1:WIDTH];
        res_fix = acc_nxt;
        if (!op_q[1])
            res_fix = neg_res ? (~acc_nxt + 1'b1) : acc_nxt;
        else
            res_fix = {rem, quo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            opd_q   <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
            dbz_o   <= 1'b0;
            res_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !cancel_i) begin
                        dbz_o   <= 1'b0;
                        op_q    <= op_i;
                        cnt     <= '0;
                        neg_res <= s1_neg ^ s2_neg;
                        neg_rem <= s1_neg & op_i[1];
                        if (op_i[1] && src2_i == '0) begin
                            state   <= DONE;
                            ready_o <= 1'b1;
                            dbz_o   <= 1'b1;
                            res_o   <= {src1_i, {WIDTH{1'b1}}};
                        end else begin
                            state  <= CALC;
                            busy_o <= 1'b1;
                            opd_q  <= op_i[1] ? abs2 : abs1;
                            acc    <= {{WIDTH{1'b0}}, op_i[1] ? abs1 : abs2};
                        end
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state   <= DONE;
                            busy_o  <= 1'b0;
                            ready_o <= 1'b1;
                            res_o   <= res_fix;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_o <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - table-driven self-checking bench for mdu_iter
module tb_mdu_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic         cancel_i = 1'b0;
    logic         busy_o;
    logic         ready_o;
    logic [2*W-1:0] res_o;
    logic         dbz_o;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           dbz;
        int             lat;
    } vec_t;

    vec_t vecs[13];

    mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .cancel_i(cancel_i),
        .busy_o(busy_o), .ready_o(ready_o), .res_o(res_o), .dbz_o(dbz_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op at edge 0 and returns the cycle in which ready_o is seen.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!ready_o && lat < 100) begin
            if (busy_o) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, seen;
        vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0, 33};
        vecs[1]  = '{DIVU,  32'd100,      32'd7,        {32'd2, 32'd14},       1'b0, 33};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 33};
        vecs[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0, 33};
        vecs[4]  = '{DIV,   32'h1234,     32'd0,        {32'h1234, 32'hFFFFFFFF}, 1'b1, 1};
        vecs[5]  = '{DIVU,  32'd9,        32'd3,        {32'd0, 32'd3},        1'b0, 33};
        vecs[6]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 33};
        vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 33};
        vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0, 33};
        vecs[9]  = '{DIVU,  32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF}, 1'b0, 33};
        vecs[10] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1,                 1'b0, 33};
        vecs[11] = '{DIVU,  32'd5,        32'd0,        {32'd5, 32'hFFFFFFFF}, 1'b1, 1};
        vecs[12] = '{DIV,   32'hFFFFFFF8, 32'd0,        {32'hFFFFFFF8, 32'hFFFFFFFF}, 1'b1, 1};

        #12;
        chk("reset_busy",  64'(busy_o),  64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_dbz",   64'(dbz_o),   64'd0);
        chk("reset_res",   res_o,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("v%0d_lat", i),  64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_res", i),  res_o, vecs[i].res);
            chk($sformatf("v%0d_dbz", i),  64'(dbz_o), 64'(vecs[i].dbz));
            chk($sformatf("v%0d_busy", i), 64'(bc), 64'(vecs[i].lat == 1 ? 0 : 32));
        end

        // Cancel mid-CALC, then a start alongside cancel in IDLE must be dropped.
        do_op(MULTU, 32'd2, 32'd3, lat, bc);
        chk("pre_cancel_res", res_o, 64'd6);
        @(negedge clk);
        start_i = 1'b1; op_i = MULTU; src1_i = 32'd7; src2_i = 32'd7;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("cancel_busy_c10", 64'(busy_o), 64'd1);
        cancel_i = 1'b1;
        @(negedge clk);
        chk("cancel_idle_c11", 64'(busy_o), 64'd0);
        chk("cancel_ready_c11", 64'(ready_o), 64'd0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; cancel_i = 1'b0;
        chk("cancel_start_dropped", 64'(busy_o | ready_o), 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_o || busy_o) seen++;
        end
        chk("cancel_no_ready", 64'(seen), 64'd0);
        chk("cancel_res_kept", res_o, 64'd6);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        start_i = 1'b1; op_i = MULT; src1_i = 32'hFFFFFFFD; src2_i = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  64'(busy_o),  64'd0);
        chk("arst_ready", 64'(ready_o), 64'd0);
        chk("arst_res",   res_o,        64'd0);
        chk("arst_dbz",   64'(dbz_o),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(DIVU, 32'd100, 32'd7, lat, bc);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_res", res_o, {32'd2, 32'd14});
        @(negedge clk);
        chk("post_rst_ready_drop", 64'(ready_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
